text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
Parametrised character-stream front end for video_controller's write port (vc_write_enable, vc_char_in, vid_ch_addr). Accepts bytes over a valid/ready stream, buffers them in a FIFO, and tracks a cursor. Interprets CR/LF/backspace, wraps lines and screen, and performs hardware full-screen and line clears. Sits between the CPU/UART side of Computer and video_controller, replacing the tied-off write signals.

Parameters:
COLS, 80, characters per row
ROWS, 30, rows per screen
ADDR_W, 13, width of vid_ch_addr; COLS*ROWS <= 2**ADDR_W
CHAR_W, 8, character width
FIFO_DEPTH, 16, input FIFO entries (power of 2, >= 2)
CLEAR_CHAR, 8'h20, fill value for clears and backspace

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_char valid
in_char  input  CHAR_W  character/control byte
in_ready  output  1  FIFO not full
clear_req  input  1  request full-screen clear
vc_write_enable  output  1  one-cycle write strobe to video_controller
vc_char_in  output  CHAR_W  character to write
vid_ch_addr  output  ADDR_W  cell address, row*COLS+col
cursor_col  output  clog2(COLS)  current column
cursor_row  output  clog2(ROWS)  current row
busy  output  1  high in FULL_CLR or LINE_CLR

Behaviour:
- Reset (async assert, sync release): vc_write_enable=0, vc_char_in=0, vid_ch_addr=0, cursor=(0,0), FIFO empty, in_ready=1, state=FULL_CLR, clear counter=0, busy=1.
- FIFO: push on in_valid&&in_ready; in_ready=!full; pushes allowed in every state. Pop only in IDLE.
- States: IDLE, FULL_CLR, LINE_CLR. All vc_* outputs registered; vc_write_enable high exactly one cycle per write; at most one write per cycle.
- FULL_CLR: writes CLEAR_CHAR to addresses 0..COLS*ROWS-1, one per cycle ascending; then cursor=(0,0), -> IDLE. clear_req ignored while in FULL_CLR/LINE_CLR.
- IDLE priority: clear_req -> FULL_CLR (FIFO contents retained, processed afterwards); else if FIFO non-empty, pop one byte and act:
  - 0x0D: col=0; no write.
  - 0x0A: col=0, advance row; no write; -> LINE_CLR.
  - 0x08: if col>0, col-1 and write CLEAR_CHAR at new position; col==0: no-op, no write.
  - any other byte: write at row*COLS+col; col+1. If col was COLS-1, col=0, advance row, -> LINE_CLR.
- Advance row: row+1; from ROWS-1 wraps to 0 (no scroll).
- LINE_CLR: writes CLEAR_CHAR to row*COLS .. row*COLS+COLS-1 (new row) ascending, COLS cycles, then IDLE.
- Address arithmetic: row base held in a register incremented by COLS (reset to 0 on wrap); no multiplier; result truncated to ADDR_W.
- Latency: byte accepted at edge k into empty FIFO in IDLE -> popped at edge k+1 -> vc_write_enable high the cycle following edge k+1. Sustained throughput one printable byte/cycle.
- cursor_col/cursor_row reflect position after the most recent popped byte.
- Simultaneous push and pop: both occur; count unchanged.
- rst during any clear or write: all state to reset values; full clear restarts at address 0; FIFO discarded.

Test Plan:
- Release reset, no input -> exactly 2400 strobes, addresses 0..2399 ascending, char 0x20, busy high throughout, then busy=0, cursor (0,0).
- After clear, send 'A' (0x41) -> single strobe addr 0, char 0x41, two cycles after acceptance; cursor (1,0).
- Send 80 printable bytes then 'Z' -> writes addr 0..79, then 80 clears addr 80..159, then 'Z' at addr 80; cursor (1,1).
- Cursor at row 29 col 5, send 0x0A -> no char write, clears addr 0..79, cursor (0,0); then 0x08 -> no write; then 'B',0x08 -> 'B' at 0, 0x20 at 0, cursor (0,0).
- Hold in_valid during FULL_CLR with 20 bytes -> in_ready drops after 16 accepted; after clear, all 16 written in order at addr 0..15, remaining 4 accepted as space frees.
- clear_req asserted same cycle as a byte pending in IDLE -> FULL_CLR runs first, pending byte then written at addr 0; rst asserted mid-clear at addr 1000 -> strobes stop immediately, new clear restarts from 0.

Source files
------------

// File: rtl/text_console_writer.sv
// text_console_writer: FIFO-buffered character stream to video_controller cell writes with cursor and clears
module text_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int ADDR_W = 13,
  parameter int CHAR_W = 8,
  parameter int FIFO_DEPTH = 16,
  parameter logic [CHAR_W-1:0] CLEAR_CHAR = 8'h20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [CHAR_W-1:0]          in_char,
  output logic                       in_ready,
  input  logic                       clear_req,
  output logic                       vc_write_enable,
  output logic [CHAR_W-1:0]          vc_char_in,
  output logic [ADDR_W-1:0]          vid_ch_addr,
  output logic [$clog2(COLS)-1:0]    cursor_col,
  output logic [$clog2(ROWS)-1:0]    cursor_row,
  output logic                       busy
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CHAR_W-1:0] CH_CR = CHAR_W'(8'h0D);
  localparam logic [CHAR_W-1:0] CH_LF = CHAR_W'(8'h0A);
  localparam logic [CHAR_W-1:0] CH_BS = CHAR_W'(8'h08);
  typedef enum logic [1:0] {IDLE, FULL_CLR, LINE_CLR} state_t;
  state_t state;
  logic [CHAR_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] row_base, clr_addr, next_base;
  logic [CW-1:0] clr_col;
  logic [RW-1:0] next_row;
  logic [CHAR_W-1:0] head;
  logic full, empty, push, pop, last_col, last_row;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign in_ready = !full;
  assign push = in_valid && !full;
  assign pop = state == IDLE && !clear_req && !empty;
  assign head = mem[rd_ptr[AW-1:0]];
  assign last_col = cursor_col == CW'(COLS - 1);
  assign last_row = cursor_row == RW'(ROWS - 1);
  // Row wrap is a plain jump back to the top: no scrolling, base register avoids a multiplier
  assign next_row = last_row ? '0 : cursor_row + 1'b1;
  assign next_base = last_row ? '0 : row_base + ADDR_W'(COLS);
  always_ff @(posedge clk) if (push) mem[wr_ptr[AW-1:0]] <= in_char;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FULL_CLR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      row_base <= '0;
      clr_addr <= '0;
      clr_col <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      vc_write_enable <= 1'b0;
      vc_char_in <= '0;
      vid_ch_addr <= '0;
      busy <= 1'b1;
    end else begin
      vc_write_enable <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case (state)
        FULL_CLR: begin
          vc_write_enable <= 1'b1;
          vc_char_in <= CLEAR_CHAR;
          vid_ch_addr <= clr_addr;
          clr_addr <= clr_addr + 1'b1;
          busy <= 1'b1;
          if (clr_addr == ADDR_W'(COLS * ROWS - 1)) begin
            state <= IDLE;
            cursor_col <= '0;
            cursor_row <= '0;
            row_base <= '0;
          end
        end
        LINE_CLR: begin
          vc_write_enable <= 1'b1;
          vc_char_in <= CLEAR_CHAR;
          vid_ch_addr <= clr_addr;
          clr_addr <= clr_addr + 1'b1;
          clr_col <= clr_col + 1'b1;
          busy <= 1'b1;
          if (clr_col == CW'(COLS - 1)) state <= IDLE;
        end
        default: begin
          busy <= 1'b0;
          if (clear_req) begin
            state <= FULL_CLR;
            clr_addr <= '0;
            busy <= 1'b1;
          end else if (!empty) begin
            if (head == CH_CR) begin
              cursor_col <= '0;
            end else if (head == CH_LF) begin
              cursor_col <= '0;
              cursor_row <= next_row;
              row_base <= next_base;
              clr_addr <= next_base;
              clr_col <= '0;
              state <= LINE_CLR;
              busy <= 1'b1;
            end else if (head == CH_BS) begin
              if (cursor_col != '0) begin
                cursor_col <= cursor_col - 1'b1;
                vc_write_enable <= 1'b1;
                vc_char_in <= CLEAR_CHAR;
                vid_ch_addr <= row_base + ADDR_W'(cursor_col - 1'b1);
              end
            end else begin
              vc_write_enable <= 1'b1;
              vc_char_in <= head;
              vid_ch_addr <= row_base + ADDR_W'(cursor_col);
              cursor_col <= last_col ? '0 : cursor_col + 1'b1;
              if (last_col) begin
                cursor_row <= next_row;
                row_base <= next_base;
                clr_addr <= next_base;
                clr_col <= '0;
                state <= LINE_CLR;
                busy <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: directed-plus-random bench against a screen-level reference model
module tb_text_console_writer;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int N = COLS * ROWS;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clear_req = 1'b0;
  logic [7:0] in_char = '0;
  logic in_ready, vc_write_enable, busy;
  logic [7:0] vc_char_in;
  logic [12:0] vid_ch_addr;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  int passed = 0, total = 0, busy_low = 0;
  bit track = 1'b0;
  logic [31:0] got[$], exp_q[$];
  int mcol = 0, mrow = 0;
  text_console_writer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .clear_req(clear_req), .vc_write_enable(vc_write_enable), .vc_char_in(vc_char_in),
    .vid_ch_addr(vid_ch_addr), .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] pk(int a, int c);
    return (32'(a) << 8) | 32'(c & 255);
  endfunction
  always @(negedge clk) if (vc_write_enable) begin
    got.push_back(pk(int'(vid_ch_addr), int'(vc_char_in)));
    if (track && !busy) busy_low++;
  end
  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask
  task automatic m_adv();
    mrow = (mrow + 1) % ROWS;
    for (int i = 0; i < COLS; i++) exp_q.push_back(pk(mrow * COLS + i, 32));
  endtask
  task automatic m_clear();
    for (int i = 0; i < N; i++) exp_q.push_back(pk(i, 32));
    mcol = 0;
    mrow = 0;
  endtask
  task automatic m_byte(int b);
    if (b == 13) mcol = 0;
    else if (b == 10) begin
      mcol = 0;
      m_adv();
    end else if (b == 8) begin
      if (mcol > 0) begin
        mcol--;
        exp_q.push_back(pk(mrow * COLS + mcol, 32));
      end
    end else begin
      exp_q.push_back(pk(mrow * COLS + mcol, b));
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        m_adv();
      end
    end
  endtask
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_char = b;
    while (!in_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic sendm(input logic [7:0] b);
    send(b);
    m_byte(int'(b));
  endtask
  task automatic pulse_clear();
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
  endtask
  task automatic drain(string tag);
    int t, n, bad, idx;
    t = 0;
    while (got.size() < exp_q.size() && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    n = got.size() < exp_q.size() ? got.size() : exp_q.size();
    bad = -1;
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) begin
      bad = i;
      break;
    end
    if (n > 0) begin
      idx = bad < 0 ? n - 1 : bad;
      check({tag, "_write"}, 64'(got[idx]), 64'(exp_q[idx]));
    end
    check({tag, "_col"}, 64'(cursor_col), 64'(mcol));
    check({tag, "_row"}, 64'(cursor_row), 64'(mrow));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    got.delete();
    exp_q.delete();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int m, t;
    logic [7:0] b;
    repeat (2) @(negedge clk);
    check("rst_we", 64'(vc_write_enable), 64'd0);
    check("rst_addr", 64'(vid_ch_addr), 64'd0);
    check("rst_char", 64'(vc_char_in), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_cursor", 64'({cursor_row, cursor_col}), 64'd0);
    track = 1'b1;
    m_clear();
    rst = 1'b0;
    drain("init");
    check("init_busy_high", 64'(busy_low), 64'd0);
    track = 1'b0;
    send(8'h41);
    @(negedge clk);
    check("lat_early", 64'(vc_write_enable), 64'd0);
    @(negedge clk);
    check("lat_we", 64'(vc_write_enable), 64'd1);
    check("lat_addr", 64'(vid_ch_addr), 64'd0);
    check("lat_char", 64'(vc_char_in), 64'h41);
    m_byte(8'h41);
    drain("single");
    sendm(8'h0D);
    for (int i = 0; i < COLS; i++) sendm(8'($urandom_range(32, 126)));
    sendm(8'h5A);
    drain("line_wrap");
    for (int i = 0; i < 28; i++) sendm(8'h0A);
    for (int i = 0; i < 5; i++) sendm(8'($urandom_range(32, 126)));
    drain("walk");
    sendm(8'h0A);
    drain("lf_wrap");
    sendm(8'h08);
    drain("bs_col0");
    sendm(8'h42);
    sendm(8'h08);
    drain("bs");
    pulse_clear();
    m_clear();
    for (int i = 0; i < 16; i++) sendm(8'($urandom_range(32, 126)));
    @(negedge clk);
    check("fifo_full_ready", 64'(in_ready), 64'd0);
    check("fifo_full_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) sendm(8'($urandom_range(32, 126)));
    drain("fifo");
    b = 8'($urandom_range(32, 126));
    @(negedge clk);
    in_valid = 1'b1;
    in_char = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
    m_clear();
    m_byte(int'(b));
    drain("clr_prio");
    pulse_clear();
    t = 0;
    while (!(vc_write_enable && vid_ch_addr == 13'd1000) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("reach_1000", 64'(vid_ch_addr), 64'd1000);
    rst = 1'b1;
    #1;
    check("mid_rst_we", 64'(vc_write_enable), 64'd0);
    check("mid_rst_addr", 64'(vid_ch_addr), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd1);
    m = got.size();
    repeat (3) @(negedge clk);
    check("mid_rst_quiet", 64'(got.size()), 64'(m));
    got.delete();
    exp_q.delete();
    track = 1'b1;
    busy_low = 0;
    m_clear();
    rst = 1'b0;
    drain("restart");
    check("restart_busy_high", 64'(busy_low), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
